// File: rtl/b06_trace_capture_pkg.sv
// Shared types and constants for the b06 trace capture stage.
package b06_trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } trace_state_e;

  localparam int unsigned VEC_W     = 6;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  localparam int unsigned TAP_A = 15;
  localparam int unsigned TAP_B = 14;
  localparam int unsigned TAP_C = 12;
  localparam int unsigned TAP_D = 3;

  // One MISR step: shift in the tap feedback, then fold the sample into the low bits.
  function automatic logic [15:0] misr_step(input logic [15:0] sig,
                                            input logic [VEC_W-1:0] vec);
    logic fb;
    fb = sig[TAP_A] ^ sig[TAP_B] ^ sig[TAP_C] ^ sig[TAP_D];
    return {sig[14:0], fb} ^ {{(16-VEC_W){1'b0}}, vec};
  endfunction

endpackage

// File: rtl/b06_trace_capture_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only with a same-cycle pop.
module trace_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             push_accept_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             pop_ok;

  assign empty_o       = (count_q == '0);
  assign full_o        = (count_q == FULL_CNT);
  assign pop_ok        = pop_i && !empty_o;
  assign push_accept_o = push_i && (!full_o || pop_ok);
  assign data_o        = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; flush and reset both drop all entries.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_accept_o) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)        rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_accept_o, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care until pointed at by a valid count.
  always_ff @(posedge clk_i) begin
    if (push_accept_o) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/b06_trace_capture.sv
// Observes the b06 outputs, logs time-stamped changes into a FIFO and folds every sample into a MISR.
module b06_trace_capture
  import b06_trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned STAMP_W = 10
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [1:0]               cc_mux,
  input  logic [1:0]               uscite,
  input  logic                     enable_count,
  input  logic                     ackout,
  input  logic                     arm,
  input  logic                     stop,
  input  logic                     rd_en,
  output logic [STAMP_W+VEC_W-1:0] rd_data,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     capturing,
  output logic [15:0]              signature
);

  trace_state_e     state_q;
  logic [STAMP_W-1:0] stamp_q;
  logic [VEC_W-1:0] prev_vec_q;
  logic             first_q;
  logic [15:0]      sig_q;
  logic             overflow_q;
  logic             capturing_q;

  logic [VEC_W-1:0] vec;
  logic             sample;
  logic             push;
  logic             push_accept;

  assign vec    = {cc_mux, uscite, enable_count, ackout};
  // arm and stop cycles are never sampled, so both gate the sample strobe.
  assign sample = (state_q == CAPTURE) && !arm && !stop;
  assign push   = sample && (first_q || (vec != prev_vec_q));

  trace_fifo #(
    .WIDTH (STAMP_W + VEC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i         (clock),
    .rst_i         (reset),
    .flush_i       (arm),
    .push_i        (push),
    .data_i        ({stamp_q, vec}),
    .pop_i         (rd_en),
    .data_o        (rd_data),
    .empty_o       (empty),
    .full_o        (full),
    .push_accept_o (push_accept)
  );

  // Capture FSM with stamp counter, change detector, MISR and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      capturing_q <= 1'b0;
      stamp_q     <= '0;
      prev_vec_q  <= '0;
      first_q     <= 1'b0;
      sig_q       <= '0;
      overflow_q  <= 1'b0;
    end else if (arm) begin
      state_q     <= CAPTURE;
      capturing_q <= 1'b1;
      stamp_q     <= '0;
      first_q     <= 1'b1;
      sig_q       <= MISR_SEED;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (stop) begin
            state_q     <= DONE;
            capturing_q <= 1'b0;
          end else begin
            sig_q      <= misr_step(sig_q, vec);
            prev_vec_q <= vec;
            first_q    <= 1'b0;
            stamp_q    <= stamp_q + 1'b1;
            if (push && !push_accept) overflow_q <= 1'b1;
            if (stamp_q == '1) begin
              state_q     <= DONE;
              capturing_q <= 1'b0;
            end
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign overflow  = overflow_q;
  assign capturing = capturing_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_b06_trace_capture.sv
// Directed self-checking bench for b06_trace_capture (DEPTH=8, STAMP_W=10).
module tb_b06_trace_capture;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  cc_mux;
  logic [1:0]  uscite;
  logic        enable_count;
  logic        ackout;
  logic        arm;
  logic        stop;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        capturing;
  logic [15:0] signature;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  b06_trace_capture #(
    .DEPTH   (8),
    .STAMP_W (10)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cc_mux       (cc_mux),
    .uscite       (uscite),
    .enable_count (enable_count),
    .ackout       (ackout),
    .arm          (arm),
    .stop         (stop),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .overflow     (overflow),
    .capturing    (capturing),
    .signature    (signature)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_vec(input logic [5:0] v);
    {cc_mux, uscite, enable_count, ackout} = v;
  endtask

  function automatic logic [15:0] ent(input int s, input logic [5:0] v);
    logic [9:0] s10;
    s10 = s[9:0];
    return {s10, v};
  endfunction

  initial begin
    reset = 1'b1; arm = 1'b0; stop = 1'b0; rd_en = 1'b0;
    set_vec(6'b000000);
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check_eq("rst_empty", empty, 1);
    check_eq("rst_capt", capturing, 0);
    check_eq("rst_sig", signature, 16'h0000);
    check_eq("rst_rddata", rd_data, 0);

    // Activity without arm leaves everything idle
    for (int i = 0; i < 10; i++) begin
      set_vec(6'((i * 7) ^ 6'h2a));
      stop  = i[0];
      rd_en = ~i[0];
      tick();
    end
    stop = 1'b0; rd_en = 1'b0;
    check_eq("noarm_empty", empty, 1);
    check_eq("noarm_capt", capturing, 0);
    check_eq("noarm_sig", signature, 16'h0000);
    check_eq("noarm_full", full, 0);
    check_eq("noarm_ovf", overflow, 0);

    // Constant zero vector for 5 samples
    arm = 1'b1; set_vec(6'b000000);
    tick();
    arm = 1'b0;
    check_eq("arm_capt", capturing, 1);
    check_eq("arm_seed", signature, 16'hFFFF);
    check_eq("arm_empty", empty, 1);
    repeat (5) tick();
    check_eq("z5_sig", signature, 16'hFFE1);
    check_eq("z5_capt", capturing, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check_eq("z5_stop_capt", capturing, 0);
    tick();
    check_eq("z5_sig_frozen", signature, 16'hFFE1);
    check_eq("z5_empty", empty, 0);
    check_eq("z5_entry", rd_data, ent(0, 6'b000000));
    rd_en = 1'b1;
    tick();
    check_eq("z5_pop_empty", empty, 1);
    tick();
    rd_en = 1'b0;
    check_eq("pop_on_empty", empty, 1);
    check_eq("pop_on_empty_full", full, 0);

    // Change detection: 0,0,0,100000,100001 then stop
    arm = 1'b1; set_vec(6'b000000);
    tick();
    arm = 1'b0;
    repeat (3) tick();
    set_vec(6'b100000); tick();
    set_vec(6'b100001); tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("chg_e0", rd_data, ent(0, 6'b000000));
    rd_en = 1'b1; tick();
    check_eq("chg_e1", rd_data, ent(3, 6'b100000));
    tick();
    check_eq("chg_e2", rd_data, ent(4, 6'b100001));
    tick();
    rd_en = 1'b0;
    check_eq("chg_empty", empty, 1);

    // Overflow: 10 changes into 8 entries
    arm = 1'b1; set_vec(6'b000000);
    tick();
    arm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_vec({5'b0, i[0]});
      tick();
    end
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("ovf_full", full, 1);
    check_eq("ovf_flag", overflow, 1);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("ovf_e%0d", i), rd_data, ent(i, {5'b0, i[0]}));
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    check_eq("ovf_drained", empty, 1);
    check_eq("ovf_sticky", overflow, 1);
    arm = 1'b1; tick(); arm = 1'b0;
    check_eq("ovf_rearm_clr", overflow, 0);
    stop = 1'b1; tick(); stop = 1'b0;

    // Push into a full FIFO with a same-cycle pop
    arm = 1'b1; set_vec(6'b000000);
    tick();
    arm = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_vec({5'b0, i[0]});
      tick();
    end
    check_eq("fp_full", full, 1);
    check_eq("fp_ovf0", overflow, 0);
    set_vec(6'b000000); rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_eq("fp_still_full", full, 1);
    check_eq("fp_no_ovf", overflow, 0);
    check_eq("fp_head", rd_data, ent(1, 6'b000001));
    stop = 1'b1; tick(); stop = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check_eq($sformatf("fp_e%0d", i), rd_data, ent(i, {5'b0, i[0]}));
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    check_eq("fp_drained", empty, 1);

    // arm beats stop; mid-capture reset
    arm = 1'b1; stop = 1'b1; set_vec(6'b000000);
    tick();
    arm = 1'b0; stop = 1'b0;
    check_eq("arm_beats_stop", capturing, 1);
    set_vec(6'b000001); tick();
    set_vec(6'b000010); tick();
    set_vec(6'b000011); tick();
    check_eq("mr_pre_empty", empty, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    check_eq("mr_empty", empty, 1);
    check_eq("mr_capt", capturing, 0);
    check_eq("mr_sig", signature, 16'h0000);
    check_eq("mr_rddata", rd_data, 0);
    tick();
    check_eq("mr_idle", capturing, 0);
    arm = 1'b1; set_vec(6'b010110); tick(); arm = 1'b0;
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("mr_rearm_entry", rd_data, ent(0, 6'b010110));
    check_eq("mr_rearm_sig", signature, 16'hFFE8);

    // Stamp saturation ends the capture after stamp 1023 is sampled
    arm = 1'b1; set_vec(6'b000000); tick(); arm = 1'b0;
    repeat (1023) tick();
    check_eq("sat_before", capturing, 1);
    tick();
    check_eq("sat_after", capturing, 0);
    check_eq("sat_entry", rd_data, ent(0, 6'b000000));
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check_eq("sat_single", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/b06_trace_capture.md
# b06_trace_capture

Downstream observation stage for the b06 controller. It samples the four b06 outputs (cc_mux, uscite, enable_count, ackout) every clock. On each change it records a time-stamped entry in a small FIFO and folds every captured sample into a 16-bit MISR signature. Regression benches and on-chip debug read back the change trace and compare one signature word instead of strobing raw outputs each cycle.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, ≥2.
- STAMP_W, 10: width of the cycle stamp.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- cc_mux  in  2  b06 output.
- uscite  in  2  b06 output.
- enable_count  in  1  b06 output.
- ackout  in  1  b06 output.
- arm  in  1  pulse: start or restart a capture.
- stop  in  1  end capture.
- rd_en  in  1  pop head entry; ignored when empty.
- rd_data  out  STAMP_W+6  head entry {stamp, vec}; show-ahead, valid while !empty.
- empty  out  1  FIFO empty.
- full  out  1  FIFO holds DEPTH entries.
- overflow  out  1  sticky: an entry was dropped.
- capturing  out  1  state == CAPTURE.
- signature  out  16  MISR value.

## Operation
- Observation vector: vec[5:4]=cc_mux, vec[3:2]=uscite, vec[1]=enable_count, vec[0]=ackout.
- FSM states:
  - IDLE (reset state).
  - CAPTURE.
  - DONE.
- arm in any state:
  - Go to CAPTURE.
  - Flush FIFO; clear overflow.
  - Set stamp=0 and signature=16'hFFFF.
  - No sample is taken in the arm cycle.
- CAPTURE with stop=1: go to DONE. That cycle is not sampled. arm beats stop.
- CAPTURE with stop=0, per cycle:
  - Sample vec and update the MISR.
  - Push {stamp, vec} if this is the first CAPTURE cycle after arm, or if vec differs from the previously sampled vec.
  - Increment stamp.
- If stamp == 2^STAMP_W−1 when sampled: sample normally, then go to DONE automatically.
- MISR update:
  - fb = sig[15]^sig[14]^sig[12]^sig[3].
  - next sig = {sig[14:0], fb} ^ {10'b0, vec}.
- DONE and IDLE:
  - No sampling; signature frozen.
  - FIFO stays readable.
- Push when full:
  - Without a same-cycle pop: entry dropped, overflow←1.
  - With a same-cycle pop: the push succeeds and full stays 1.
- Pop when empty: no effect.
- Reset values:
  - State IDLE, capturing=0.
  - empty=1, full=0, overflow=0.
  - signature=16'h0000, rd_data=0.
  - Stamp 0; stored previous vec 0.

## Timing
- Push registered on the sampling edge. The entry appears on rd_data, and empty falls, in the following cycle.
- The pop takes effect at the edge where rd_en=1. The next entry is presented in the following cycle.
- signature reflects all samples up to and including the previous edge.
- capturing rises the cycle after arm and falls the cycle after stop or saturation.
- Reset asserted mid-capture: all outputs take reset values at that edge. FIFO contents are lost.

## Structure
- Package b06_trace_pkg:
  - state enum {IDLE, CAPTURE, DONE}.
  - VEC_W=6.
  - MISR_SEED=16'hFFFF.
  - Tap positions 15/14/12/3.
- Sub-module trace_fifo:
  - Synchronous show-ahead FIFO, parameterised by WIDTH and DEPTH.
  - Outputs: empty, full, and push_accept.
  - The top-level block holds the FSM, stamp counter, change detector and MISR.

## Test plan
- Reset, then toggle all inputs for 10 cycles without arm → empty=1, capturing=0, signature=16'h0000.
- arm; vec=6'b000000 for 5 sampled cycles; stop → one entry {0, 6'b000000}; signature=16'hFFE1; capturing=0.
- arm; vec=0 at stamps 0–2, 6'b100000 at stamp 3, 6'b100001 at stamp 4; stop at stamp 5 → pops give entries {0, 0}, {3, 6'b100000}, {4, 6'b100001}; then empty=1.
- DEPTH=8: arm; toggle ackout every cycle for 10 cycles; no reads → 8 entries with stamps 0–7; full=1, overflow=1. Then pop all 8 and re-arm → overflow=0.
- FIFO full with rd_en=1 in the same cycle as a change at stamp 8 → head popped; {8, vec} appended; full stays 1; overflow stays 0.
- Mid-capture reset after 3 entries → next cycle: empty=1, capturing=0, signature=16'h0000. A later arm restarts stamps at 0.
